mmu: RTL and testbench
======================

Name: mmu

Overview:
- Memory/IO subsystem on the core's MMU interface; the core is its only client.
- Serves the instruction fetch port and the data load/store port from one dual-port on-chip RAM (iCE40 EBR), plus a small memory-mapped IO window: GPIO and a 64-bit cycle counter.
- Both read ports return data exactly one clock after the address, matching the core's FD-address / XB-data timing.
- Performs store lane shifting and load lane selection with sign/zero extension.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two; AW = log2(MEM_WORDS).
- INIT_FILE, "": hex image loaded into RAM at elaboration; empty means no preload.
- GPIO_OUT_W, 8: width of gpio_out.
- GPIO_IN_W, 8: width of gpio_in.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- im_addr  in  32  fetch byte address
- im_do  out  32  fetched instruction, valid one cycle after im_addr
- dm_addr  in  32  data byte address
- dm_di  in  32  store data, unshifted (rs2)
- dm_be  in  4  access size: 0001 byte, 0011 half, 1111 word, 0000 no access
- dm_we  in  1  store when 1, load when 0
- dm_is_signed  in  1  sign-extend sub-word loads
- dm_do  out  32  load result, valid one cycle after the request
- gpio_out  out  GPIO_OUT_W  output register
- gpio_in  in  GPIO_IN_W  asynchronous inputs

Behaviour:
- Clocking and reset: one clock, clk; reset resetb is asynchronous, active-low.
- Reset values:
  - im_do = 32'h00000013 (NOP).
  - dm_do = 0; gpio_out = 0; cycle counter = 0; counter-high shadow = 0; gpio_in synchronizer = 0.
  - Latched load controls are cleared, so no access is pending.
  - RAM contents are not affected by reset.
- Address decode:
  - addr[31]=0 selects RAM, word index addr[AW+1:2]; upper bits are ignored, so the RAM aliases.
  - 0x80000000: GPIO_OUT, read/write.
  - 0x80000004: GPIO_IN, read-only; value passes through a 2-flop synchronizer.
  - 0x80000008: CNT_LO, read-only.
  - 0x8000000C: CNT_HI_SHADOW, read-only.
  - Any other address with addr[31]=1: reads return 0, writes are ignored.
- Fetch port:
  - Every clock after reset, im_do <= RAM[im_addr[AW+1:2]].
  - im_addr[1:0] is ignored; the core raises instruction-misaligned itself.
  - The fetch port never writes.
- Store, when dm_we=1 and dm_be!=0:
  - Let off = dm_addr[1:0].
  - Byte: lane mask = 0001<<off; data = {4{dm_di[7:0]}}.
  - Half: mask = 0011<<off; data = {2{dm_di[15:0]}}.
  - Word: mask = 1111, data = dm_di.
  - Misaligned stores are suppressed entirely (half with off[0]=1, word with off!=0).
  - RAM byte lanes are written at the clock edge. A GPIO_OUT write applies the same lane mask to bits [GPIO_OUT_W-1:0].
- Load, when dm_we=0 and dm_be!=0:
  - At the edge, latch dm_be, off, dm_is_signed and the region select. The RAM read word is registered, and IO reads sample the register value at the request edge.
  - In the following cycle dm_do is combinational from those latched values.
  - Byte: lane off, extended.
  - Half: lane off[1], extended.
  - Word: unchanged.
  - Extension is sign extension if the latched is_signed=1, otherwise zero extension.
  - A misaligned load, or a latched dm_be=0, gives dm_do=0.
- A dm_we=1 cycle leaves dm_do=0 in the next cycle.
- RAM collisions:
  - Data read and data write to the same word cannot occur in one cycle.
  - Fetch and store to the same word in the same cycle: im_do returns the old contents (read-first).
- Cycle counter:
  - 64-bit, increments by 1 every clock after reset and wraps from 2^64-1 to 0.
  - A load from CNT_LO returns the low word and, at the same edge, copies the high word into the shadow. This makes a LO-then-HI read pair atomic.
  - The shadow changes only on a CNT_LO load.
  - Writes to counter addresses are ignored.
- Reset asserted mid-access: any pending load is dropped and dm_do goes to 0 immediately. A store launched on the same edge that reset asserts is not guaranteed.

Test Plan:
- Preload RAM[0]=0x00100093 and RAM[1]=0x00000013. Release reset with im_addr=0, then 4. Required: im_do=0x13 during reset, then 0x00100093, then 0x00000013, each exactly one cycle after the address.
- Store word 0x8899AABB to 0x10, then store byte 0xF0 to 0x13. Load LB 0x13 signed -> 0xFFFFFFF0; LBU -> 0x000000F0; LH 0x10 signed -> 0xFFFFAABB; LW -> 0xF099AABB.
- SH to address 0x11 with data 0x1234 -> suppressed; a following LW 0x10 is unchanged. LW from 0x12 -> dm_do=0.
- SW 0xA5 to 0x80000000 -> gpio_out=0xA5. Drive gpio_in=0x3C -> LW 0x80000004 returns 0x3C only after ≥2 cycles of synchronization. LW 0x80000020 -> 0.
- Force counter to 0x00000000FFFFFFFE (or run from reset). Load CNT_LO, then CNT_HI a few cycles later after the low word wraps. Required: CNT_HI returns the pre-wrap high word (0). A second LO/HI pair returns high word 1.
- Same cycle: SW 0xDEADBEEF to 0x20 with im_addr=0x20 -> im_do holds the old word. The next fetch of 0x20 returns 0xDEADBEEF.

Source files
------------

// File: rtl/mmu.sv
// mmu: single-client memory/IO subsystem serving instruction fetch and data load/store from one dual-port RAM plus GPIO and a cycle counter
module mmu #(
    parameter int MEM_WORDS  = 1024,
    parameter     INIT_FILE  = "",
    parameter int GPIO_OUT_W = 8,
    parameter int GPIO_IN_W  = 8
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic [31:0]           im_addr,
    output logic [31:0]           im_do,
    input  logic [31:0]           dm_addr,
    input  logic [31:0]           dm_di,
    input  logic [3:0]            dm_be,
    input  logic                  dm_we,
    input  logic                  dm_is_signed,
    output logic [31:0]           dm_do,
    output logic [GPIO_OUT_W-1:0] gpio_out,
    input  logic [GPIO_IN_W-1:0]  gpio_in
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [31:0] A_GPIO_OUT = 32'h8000_0000;
    localparam logic [31:0] A_GPIO_IN  = 32'h8000_0004;
    localparam logic [31:0] A_CNT_LO   = 32'h8000_0008;
    localparam logic [31:0] A_CNT_HI   = 32'h8000_000C;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    logic [31:0] mem [MEM_WORDS];

    logic [AW-1:0]         im_idx;
    logic [AW-1:0]         dm_idx;
    logic [1:0]            off;
    logic [31:0]           io_addr;
    logic                  is_ram;
    logic                  aligned;
    logic                  st_en;
    logic                  ld_en;
    logic [3:0]            st_mask;
    logic [31:0]           st_data;

    logic [31:0]           im_do_q;
    logic [31:0]           ram_rd_q;
    logic [3:0]            ld_be_q, ld_be_d;
    logic [1:0]            ld_off_q, ld_off_d;
    logic                  ld_sgn_q, ld_sgn_d;
    logic                  ld_ram_q, ld_ram_d;
    logic [31:0]           io_rd_q, io_rd_d;
    logic [GPIO_OUT_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_IN_W-1:0]  gin_s1_q, gin_s2_q;
    logic [63:0]           cnt_q;
    logic [31:0]           cnt_hi_q, cnt_hi_d;

    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    logic                  unused_im;

    assign im_idx    = im_addr[AW+1:2];
    assign dm_idx    = dm_addr[AW+1:2];
    assign off       = dm_addr[1:0];
    assign io_addr   = {dm_addr[31:2], 2'b00};
    assign is_ram    = ~dm_addr[31];
    assign unused_im = ^{im_addr[31:AW+2], im_addr[1:0]};

    // Access decode: size, alignment, store lane mask and replicated store data
    always_comb begin
        aligned = (dm_be == BE_BYTE) || (dm_be == BE_HALF && !off[0]) || (dm_be == BE_WORD && off == 2'd0);
        st_en   = dm_we & aligned;
        ld_en   = ~dm_we & aligned;
        st_mask = !aligned ? 4'b0000 :
                  (dm_be == BE_BYTE) ? (4'b0001 << off) :
                  (dm_be == BE_HALF) ? (4'b0011 << off) : 4'b1111;
        st_data = (dm_be == BE_BYTE) ? {4{dm_di[7:0]}} :
                  (dm_be == BE_HALF) ? {2{dm_di[15:0]}} : dm_di;
    end

    // Data-port RAM: byte-lane writes and registered read word
    always_ff @(posedge clk) begin
        if (st_en && is_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (st_mask[b]) mem[dm_idx][b*8 +: 8] <= st_data[b*8 +: 8];
            end
        end
        ram_rd_q <= mem[dm_idx];
    end

    // Fetch port: read-first, so a same-cycle store to the fetched word returns the old word
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) im_do_q <= 32'h0000_0013;
        else         im_do_q <= mem[im_idx];
    end

    // Next state for load controls, IO read sample, GPIO_OUT and the counter shadow
    always_comb begin
        ld_be_d  = ld_en ? dm_be : 4'b0000;
        ld_off_d = off;
        ld_sgn_d = dm_is_signed;
        ld_ram_d = is_ram;
        io_rd_d  = (io_addr == A_GPIO_OUT) ? 32'(gpio_out_q) :
                   (io_addr == A_GPIO_IN)  ? 32'(gin_s2_q) :
                   (io_addr == A_CNT_LO)   ? cnt_q[31:0] :
                   (io_addr == A_CNT_HI)   ? cnt_hi_q : 32'h0;
        cnt_hi_d = (ld_en && !is_ram && io_addr == A_CNT_LO) ? cnt_q[63:32] : cnt_hi_q;
        for (int i = 0; i < GPIO_OUT_W; i++) begin
            gpio_out_d[i] = (st_en && !is_ram && io_addr == A_GPIO_OUT && st_mask[i/8]) ? st_data[i] : gpio_out_q[i];
        end
    end

    // Control and IO registers; reset drops any pending load
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ld_be_q    <= 4'b0000;
            ld_off_q   <= 2'd0;
            ld_sgn_q   <= 1'b0;
            ld_ram_q   <= 1'b0;
            io_rd_q    <= 32'h0;
            gpio_out_q <= '0;
            gin_s1_q   <= '0;
            gin_s2_q   <= '0;
            cnt_q      <= 64'h0;
            cnt_hi_q   <= 32'h0;
        end else begin
            ld_be_q    <= ld_be_d;
            ld_off_q   <= ld_off_d;
            ld_sgn_q   <= ld_sgn_d;
            ld_ram_q   <= ld_ram_d;
            io_rd_q    <= io_rd_d;
            gpio_out_q <= gpio_out_d;
            gin_s1_q   <= gpio_in;
            gin_s2_q   <= gin_s1_q;
            cnt_q      <= cnt_q + 64'd1;
            cnt_hi_q   <= cnt_hi_d;
        end
    end

    // Load result: lane select and extension from the latched controls
    always_comb begin
        rd_word = ld_ram_q ? ram_rd_q : io_rd_q;
        rd_byte = rd_word[ld_off_q*8 +: 8];
        rd_half = ld_off_q[1] ? rd_word[31:16] : rd_word[15:0];
        dm_do   = (ld_be_q == BE_BYTE) ? {{24{ld_sgn_q & rd_byte[7]}}, rd_byte} :
                  (ld_be_q == BE_HALF) ? {{16{ld_sgn_q & rd_half[15]}}, rd_half} :
                  (ld_be_q == BE_WORD) ? rd_word : 32'h0;
    end

    assign im_do    = im_do_q;
    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_mmu.sv
// tb_mmu: directed scoreboard bench for mmu
module tb_mmu;
    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic [31:0] im_addr = 32'h0;
    logic [31:0] im_do;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_di = 32'h0;
    logic [3:0]  dm_be = 4'h0;
    logic        dm_we = 1'b0;
    logic        dm_is_signed = 1'b0;
    logic [31:0] dm_do;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in = 8'h0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mmu dut (
        .clk(clk), .resetb(resetb),
        .im_addr(im_addr), .im_do(im_do),
        .dm_addr(dm_addr), .dm_di(dm_di), .dm_be(dm_be), .dm_we(dm_we),
        .dm_is_signed(dm_is_signed), .dm_do(dm_do),
        .gpio_out(gpio_out), .gpio_in(gpio_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dacc(input logic [31:0] addr, input logic [31:0] di, input logic [3:0] be,
                        input logic we, input logic sgn, input logic [31:0] exp, input string tag);
        exp_t e;
        @(negedge clk);
        dm_addr = addr; dm_di = di; dm_be = be; dm_we = we; dm_is_signed = sgn;
        sb.push_back('{tag, exp});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, dm_do, e.exp);
        dm_be = 4'h0; dm_we = 1'b0;
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] di, input logic [3:0] be, input string tag);
        dacc(addr, di, be, 1'b1, 1'b0, 32'h0, tag);
    endtask

    task automatic ld(input logic [31:0] addr, input logic [3:0] be, input logic sgn,
                      input logic [31:0] exp, input string tag);
        dacc(addr, 32'h0, be, 1'b0, sgn, exp, tag);
    endtask

    initial begin
        st(32'h0, 32'h0010_0093, 4'hF, "pre0");
        st(32'h4, 32'h0000_0013, 4'hF, "pre1");
        chk("im_rst", im_do, 32'h0000_0013);
        chk("gpio_rst", gpio_out, 32'h0);
        @(negedge clk); resetb = 1'b1; im_addr = 32'h0;
        @(posedge clk); #1; chk("fetch0", im_do, 32'h0010_0093);
        @(negedge clk); im_addr = 32'h4;
        @(posedge clk); #1; chk("fetch1", im_do, 32'h0000_0013);
        im_addr = 32'h100;

        st(32'h10, 32'h8899_AABB, 4'hF, "sw10");
        st(32'h13, 32'h0000_00F0, 4'h1, "sb13");
        ld(32'h13, 4'h1, 1'b1, 32'hFFFF_FFF0, "lb13");
        ld(32'h13, 4'h1, 1'b0, 32'h0000_00F0, "lbu13");
        ld(32'h10, 4'h3, 1'b1, 32'hFFFF_AABB, "lh10");
        ld(32'h12, 4'h3, 1'b0, 32'h0000_F099, "lhu12");
        ld(32'h11, 4'h1, 1'b1, 32'hFFFF_FFAA, "lb11");
        ld(32'h10, 4'hF, 1'b0, 32'hF099_AABB, "lw10");
        st(32'h11, 32'h0000_1234, 4'h3, "sh11_mis");
        ld(32'h10, 4'hF, 1'b0, 32'hF099_AABB, "lw10_after_sh");
        ld(32'h12, 4'hF, 1'b0, 32'h0, "lw12_mis");
        ld(32'h1010, 4'hF, 1'b0, 32'hF099_AABB, "lw_alias");
        ld(32'h10, 4'h0, 1'b0, 32'h0, "be0");

        st(32'h8000_0000, 32'h0000_00A5, 4'hF, "gpio_sw");
        chk("gpio_out_a5", gpio_out, 32'hA5);
        st(32'h8000_0001, 32'h0000_0077, 4'h1, "gpio_sb1");
        chk("gpio_out_lane1", gpio_out, 32'hA5);
        ld(32'h8000_0000, 4'hF, 1'b0, 32'h0000_00A5, "gpio_rd");
        gpio_in = 8'h3C;
        ld(32'h8000_0004, 4'hF, 1'b0, 32'h0, "gin_sync0");
        ld(32'h8000_0004, 4'hF, 1'b0, 32'h0, "gin_sync1");
        ld(32'h8000_0004, 4'hF, 1'b0, 32'h0000_003C, "gin_sync2");
        ld(32'h8000_0020, 4'hF, 1'b0, 32'h0, "io_hole");

        force dut.cnt_q = 64'h0000_0000_FFFF_FFF8;
        #1;
        release dut.cnt_q;
        ld(32'h8000_0008, 4'hF, 1'b0, 32'hFFFF_FFF8, "cnt_lo0");
        repeat (10) @(posedge clk);
        ld(32'h8000_000C, 4'hF, 1'b0, 32'h0, "cnt_hi0");
        ld(32'h8000_0008, 4'hF, 1'b0, 32'h0000_0004, "cnt_lo1");
        ld(32'h8000_000C, 4'hF, 1'b0, 32'h0000_0001, "cnt_hi1");

        st(32'h20, 32'h1111_1111, 4'hF, "pre20");
        im_addr = 32'h20;
        st(32'h20, 32'hDEAD_BEEF, 4'hF, "sw20");
        chk("fetch_old", im_do, 32'h1111_1111);
        @(posedge clk); #1; chk("fetch_new", im_do, 32'hDEAD_BEEF);

        ld(32'h10, 4'hF, 1'b0, 32'hF099_AABB, "lw_pre_rst");
        resetb = 1'b0;
        #1;
        chk("rst_dm_do", dm_do, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_im_do", im_do, 32'h0000_0013);
        @(negedge clk); resetb = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
